// File: rtl/inst_mem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for inst_mem_loader.
interface inst_mem_loader_if #(
    parameter int unsigned AW = 10
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    // Stream source and status consumer side
    modport master (
        output start, base_addr, byte_valid, byte_data, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, word_count
    );

    // Loader side
    modport slave (
        input  start, base_addr, byte_valid, byte_data, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, word_count
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them into
// instruction memory starting at a given word address.
module inst_mem_loader #(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned AW        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_loader_if.slave bus
);

    localparam logic [1:0]    IDLE      = 2'd0;
    localparam logic [1:0]    LOAD      = 2'd1;
    localparam logic [1:0]    WRITE     = 2'd2;
    localparam int unsigned   WCW       = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_accept;
    logic [WORD_SIZE-1:0] w_asm_next;

    logic [AW-1:0]        r_addr;
    logic [1:0]           r_byte_cnt;
    logic [WORD_SIZE-1:0] r_asm;
    logic                 r_last;
    logic                 r_byte_ready;
    logic                 r_busy;
    logic                 r_wr_en;
    logic                 r_done;
    logic                 r_error;
    logic [WCW-1:0]       r_word_count;
    logic [31:0]          r_wr_addr;
    logic [WORD_SIZE-1:0] r_wr_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a byte is taken only while in LOAD (byte_ready high)
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_accept = bus.byte_valid;
                if (bus.byte_valid && ((r_byte_cnt == 2'd3) || bus.byte_last)) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                if (r_last || (r_addr == LAST_ADDR)) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Word with the incoming byte merged; first byte clears the low bytes
    always_comb begin
        w_asm_next = r_asm;
        case (r_byte_cnt)
            2'd0:    w_asm_next = {bus.byte_data, 24'h000000};
            2'd1:    w_asm_next = {r_asm[31:24], bus.byte_data, 16'h0000};
            2'd2:    w_asm_next = {r_asm[31:16], bus.byte_data, 8'h00};
            default: w_asm_next = {r_asm[31:8], bus.byte_data};
        endcase
    end

    // Datapath, status flags and state-decoded outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_byte_cnt   <= 2'd0;
            r_asm        <= '0;
            r_last       <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_wr_addr    <= 32'd0;
            r_wr_data    <= '0;
        end else begin
            r_byte_ready <= (w_state_next == LOAD);
            r_busy       <= (w_state_next != IDLE);
            r_wr_en      <= (w_state_next == WRITE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr       <= bus.base_addr;
                        r_byte_cnt   <= 2'd0;
                        r_word_count <= '0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_last       <= 1'b0;
                        r_asm        <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_asm      <= w_asm_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (bus.byte_last) begin
                            r_last <= 1'b1;
                            // Short final word: low bytes already zero
                            if (r_byte_cnt != 2'd3) begin
                                r_error <= 1'b1;
                            end
                        end
                        if (w_state_next == WRITE) begin
                            r_wr_data <= w_asm_next;
                            r_wr_addr <= 32'(r_addr);
                        end
                    end
                end
                WRITE: begin
                    r_word_count <= r_word_count + WCW'(1);
                    r_byte_cnt   <= 2'd0;
                    if (r_last) begin
                        r_done <= 1'b1;
                    end else if (r_addr == LAST_ADDR) begin
                        r_error <= 1'b1;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.busy       = r_busy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader with a byte-list reference model.
module tb_inst_mem_loader;

    localparam int unsigned AW  = 10;
    localparam int          MEM = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inst_mem_loader_if #(.AW(AW)) bus();

    inst_mem_loader #(.MEM_SIZE(MEM), .WORD_SIZE(32), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  b [64];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic        exp_done;
    logic        exp_err;

    // Capture every write strobe away from the rising edge
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_addr.push_back(bus.wr_addr);
            got_data.push_back(bus.wr_data);
        end
    end

    // Reference: walk the accepted byte list, 4 bytes per word big-endian
    task automatic model(input int base, input int n, input int last_idx);
        int          addr;
        int          k;
        logic [31:0] word;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        addr = base;
        k    = 0;
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[31-8*k -: 8] = b[i];
            k++;
            if (i == last_idx) begin
                exp_addr.push_back(32'(addr));
                exp_data.push_back(word);
                exp_done = 1'b1;
                exp_err  = (k != 4);
                break;
            end
            if (k == 4) begin
                exp_addr.push_back(32'(addr));
                exp_data.push_back(word);
                word = '0;
                k    = 0;
                if (addr == MEM - 1) begin
                    exp_err = 1'b1;
                    break;
                end
                addr++;
            end
        end
    endtask

    // Start a load and stream n bytes; gap inserts idle cycles, midstart pulses start
    task automatic run_load(input int base, input int n, input int last_idx,
                            input bit gap, input bit midstart);
        int   i;
        int   cyc;
        bit   tog;
        logic rdy;
        got_addr.delete();
        got_data.delete();
        @(posedge clk); #1;
        bus.base_addr = AW'(base);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        i   = 0;
        cyc = 0;
        tog = 1'b0;
        while (i < n && cyc < 600) begin
            if (gap && tog) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                bus.byte_last  = 1'($urandom);
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = b[i];
                bus.byte_last  = (i == last_idx);
            end
            bus.start     = midstart && (cyc == 7);
            bus.base_addr = midstart ? AW'(base + 17) : AW'(base);
            rdy = bus.byte_ready;
            @(posedge clk); #1;
            if (bus.byte_valid && rdy) i++;
            tog = !tog;
            cyc++;
            if (!bus.busy) break;
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.start      = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.wr_en, bus.byte_ready, bus.busy, bus.done, bus.error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.wr_en, bus.byte_ready, bus.busy, bus.done, bus.error});
        end
        total++;
        if (bus.word_count !== '0 || bus.wr_addr !== 32'd0 || bus.wr_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got wc=%0d addr=%h data=%h exp 0",
                     bus.word_count, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got ready=%b busy=%b exp 0 0", bus.byte_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) b[i] = 8'(i + 1);
        run_load(0, 8, 7, 1'b0, 1'b0);
        total++;
        if (got_addr.size() != 2) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=2", got_addr.size());
        end else begin
            total++;
            if (got_addr[0] !== 32'd0 || got_data[0] !== 32'h01020304) begin
                bad++;
                $display("FAIL basic_w0 got=%h@%0d exp=01020304@0", got_data[0], got_addr[0]);
            end
            total++;
            if (got_addr[1] !== 32'd1 || got_data[1] !== 32'h05060708) begin
                bad++;
                $display("FAIL basic_w1 got=%h@%0d exp=05060708@1", got_data[1], got_addr[1]);
            end
        end
        total++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.word_count !== 11'd2) begin
            bad++;
            $display("FAIL basic_status got done=%b err=%b wc=%0d exp 1 0 2",
                     bus.done, bus.error, bus.word_count);
        end
    endtask

    task automatic test_short();
        b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC;
        run_load(5, 3, 2, 1'b0, 1'b0);
        total++;
        if (got_addr.size() != 1 || got_addr[0] !== 32'd5 || got_data[0] !== 32'hAABBCC00) begin
            bad++;
            $display("FAIL short_word got n=%0d first=%h exp n=1 AABBCC00@5",
                     got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        end
        total++;
        if (bus.done !== 1'b1 || bus.error !== 1'b1 || bus.word_count !== 11'd1) begin
            bad++;
            $display("FAIL short_status got done=%b err=%b wc=%0d exp 1 1 1",
                     bus.done, bus.error, bus.word_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
        model(1022, 12, -1);
        run_load(1022, 12, -1, 1'b0, 1'b0);
        total++;
        if (got_addr.size() != 2) begin
            bad++;
            $display("FAIL ovf_count got=%0d exp=2", got_addr.size());
        end
        for (int j = 0; j < exp_addr.size(); j++) begin
            total++;
            if (j >= got_addr.size() || got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) begin
                bad++;
                $display("FAIL ovf_word%0d exp=%h@%0d", j, exp_data[j], exp_addr[j]);
            end
        end
        total++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.byte_ready !== 1'b0 ||
            bus.word_count !== 11'd2 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_status got err=%b done=%b rdy=%b wc=%0d busy=%b exp 1 0 0 2 0",
                     bus.error, bus.done, bus.byte_ready, bus.word_count, bus.busy);
        end
    endtask

    task automatic test_gaps();
        int base;
        base = $urandom_range(0, 900);
        for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
        model(base, 12, 11);
        run_load(base, 12, 11, 1'b1, 1'b1);
        total++;
        if (got_addr.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL gap_count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
        end
        for (int j = 0; j < exp_addr.size(); j++) begin
            total++;
            if (j >= got_addr.size() || got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) begin
                bad++;
                $display("FAIL gap_word%0d exp=%h@%0d", j, exp_data[j], exp_addr[j]);
            end
        end
        total++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.word_count !== 11'd3) begin
            bad++;
            $display("FAIL gap_status got done=%b err=%b wc=%0d exp 1 0 3",
                     bus.done, bus.error, bus.word_count);
        end
    endtask

    task automatic test_reset_midload();
        got_addr.delete();
        got_data.delete();
        @(posedge clk); #1;
        bus.base_addr = '0;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h11;
        @(posedge clk); #1;
        bus.byte_data  = 8'h22;
        @(posedge clk); #3;
        bus.byte_data  = 8'h33;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.wr_en, bus.byte_ready, bus.busy, bus.done, bus.error} !== 5'b0 ||
            bus.word_count !== '0 || bus.wr_addr !== 32'd0 || bus.wr_data !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got flags=%b wc=%0d data=%h exp all 0",
                     {bus.wr_en, bus.byte_ready, bus.busy, bus.done, bus.error},
                     bus.word_count, bus.wr_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (got_addr.size() != 0 || bus.byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_write got writes=%0d rdy=%b exp 0 0", got_addr.size(), bus.byte_ready);
        end
        bus.byte_valid = 1'b0;
        b[0] = 8'hDE; b[1] = 8'hAD; b[2] = 8'hBE; b[3] = 8'hEF;
        run_load(0, 4, 3, 1'b0, 1'b0);
        total++;
        if (got_addr.size() != 1 || got_addr[0] !== 32'd0 || got_data[0] !== 32'hDEADBEEF ||
            bus.done !== 1'b1 || bus.error !== 1'b0) begin
            bad++;
            $display("FAIL reload got n=%0d done=%b err=%b exp 1 write DEADBEEF@0 done=1 err=0",
                     got_addr.size(), bus.done, bus.error);
        end
    endtask

    task automatic test_random();
        int base;
        int n;
        for (int it = 0; it < 10; it++) begin
            base = (it % 2 == 1) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
            n    = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) b[i] = 8'($urandom);
            model(base, n, n - 1);
            run_load(base, n, n - 1, 1'($urandom), 1'b0);
            total++;
            if (got_addr.size() != exp_addr.size()) begin
                bad++;
                $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_addr.size(), exp_addr.size());
            end
            for (int j = 0; j < exp_addr.size(); j++) begin
                total++;
                if (j >= got_addr.size() || got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) begin
                    bad++;
                    $display("FAIL rand%0d_word%0d exp=%h@%0d", it, j, exp_data[j], exp_addr[j]);
                end
            end
            total++;
            if (bus.done !== exp_done || bus.error !== exp_err || bus.busy !== 1'b0 ||
                bus.word_count !== 11'(exp_addr.size())) begin
                bad++;
                $display("FAIL rand%0d_status got done=%b err=%b busy=%b wc=%0d exp %b %b 0 %0d",
                         it, bus.done, bus.error, bus.busy, bus.word_count,
                         exp_done, exp_err, exp_addr.size());
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_last  = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_overflow();
        test_gaps();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter MEM_SIZE, default 1024, number of 32-bit words in the target instruction memory.
REQ-002 Parameter WORD_SIZE, default 32, instruction word width; only 32 is supported.
REQ-003 Parameter AW, default 10, word-address width, equal to log2(MEM_SIZE).
REQ-004 Clocking: one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to begin a program load; sampled only in IDLE.
REQ-008 base_addr  in  AW  word address for the first instruction; sampled with start.
REQ-009 byte_valid  in  1  byte_data is valid this cycle.
REQ-010 byte_data  in  8  incoming program byte.
REQ-011 byte_last  in  1  qualifies byte_data as the final byte of the program.
REQ-012 byte_ready  out  1  loader accepts a byte this cycle.
REQ-013 wr_en  out  1  one-cycle instruction-memory write strobe.
REQ-014 wr_addr  out  32  instruction-memory word address; bits 31:AW are zero.
REQ-015 wr_data  out  32  assembled instruction word.
REQ-016 busy  out  1  load in progress.
REQ-017 done  out  1  last load completed; sticky until the next start.
REQ-018 error  out  1  last load ended abnormally; sticky until the next start.
REQ-019 word_count  out  AW+1  number of words written in the current or last load.

Function
REQ-020 FSM states: IDLE, LOAD and WRITE; all outputs are registered or decoded from the state only.
REQ-021 IDLE: byte_ready=0 and busy=0; on start=1, go to LOAD and make these assignments:
- addr<=base_addr
- byte_cnt<=0
- word_count<=0
- done<=0
- error<=0
REQ-022 LOAD: byte_ready=1 and busy=1; a byte is accepted only when byte_valid=1 and byte_ready=1.
REQ-023 Byte order is big-endian: the 1st accepted byte goes to wr_data[31:24] and the 4th to [7:0]; byte_cnt is 2 bits and wraps 3->0.
REQ-024 On acceptance of the 4th byte, or of any byte with byte_last=1, go to WRITE on the next edge.
REQ-025 When byte_last arrives on byte k<4 of a word, the unfilled low bytes of wr_data are zero and error is set.
REQ-026 WRITE, duration exactly one cycle:
- wr_en=1, byte_ready=0
- wr_addr = current addr, wr_data = assembled word
- word_count increments at the end of the cycle
REQ-027 Exit from WRITE when the word carried byte_last: go to IDLE with done=1.
REQ-028 Exit from WRITE when addr=MEM_SIZE-1 and no byte_last: go to IDLE with error=1 and done=0 (overflow); no further writes.
REQ-029 Otherwise exit from WRITE to LOAD with addr+1.
REQ-030 Latency: wr_en rises exactly one cycle after the edge that accepted the word's final byte.
REQ-031 Full-rate stream: 4 bytes per word followed by one WRITE bubble, giving 5 cycles per word.
REQ-032 start while busy=1 is ignored; byte_valid outside LOAD is ignored and not accepted.
REQ-033 byte_last on a byte with byte_valid=0 has no effect.
REQ-034 wr_en is never asserted outside WRITE; wr_data and wr_addr hold their values when wr_en=0.

Reset
REQ-035 rst_n=0 forces IDLE immediately, regardless of clk.
REQ-036 Reset values: wr_en=0, byte_ready=0, busy=0, done=0, error=0, word_count=0, wr_addr=0, wr_data=0, byte_cnt=0.
REQ-037 Reset mid-load discards the partially assembled word with no write, and requires a new start after release.

Verification
REQ-038 base_addr=0, start, bytes 01 02 03 04 05 06 07 08 with byte_last on 08. Required: wr_en at addr 0 with 0x01020304, then at addr 1 with 0x05060708; done=1, error=0, word_count=2.
REQ-039 base_addr=5, bytes AA BB CC with byte_last on CC. Required: one write at addr 5 with 0xAABBCC00; done=1, error=1, word_count=1.
REQ-040 base_addr=1022, 12 bytes with no byte_last. Required: writes at 1022 and 1023 only; error=1, done=0, byte_ready=0 afterwards, word_count=2.
REQ-041 byte_valid toggled every other cycle, plus start pulsed mid-load. Required: bytes are accepted only when valid&&ready, words are identical to the gapless case, and start has no effect.
REQ-042 rst_n pulled low asynchronously after 2 bytes of a word. Required: outputs at reset values within the same cycle; no wr_en; a later load at base_addr=0 writes correctly.
